// File: rtl/hazard_ctrl.sv
// hazard_ctrl: E/M/W scoreboard driving forwarding, load-use stalls, branch flushes and the mul/div handshake.
// Define HAZARD_CTRL_PERF_EN to add saturating load-use, branch and mul/div wait counters.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int NSTAGE_TRK = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_ra1,
    input  logic [REG_AW-1:0] i_id_ra2,
    input  logic              i_id_use1,
    input  logic              i_id_use2,
    input  logic              i_id_wen,
    input  logic [REG_AW-1:0] i_id_wra,
    input  logic              i_id_load,
    input  logic              i_id_md,
    input  logic              i_ex_br_taken,
    input  logic              i_md_done,
    output logic              o_stall_f,
    output logic              o_stall_d,
    output logic              o_stall_e,
    output logic              o_flush_d,
    output logic              o_flush_e,
    output logic              o_md_start,
    output logic [1:0]        o_fwd1,
    output logic [1:0]        o_fwd2,
    output logic              o_md_busy
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]       o_cnt_lu,
    output logic [31:0]       o_cnt_br,
    output logic [31:0]       o_cnt_md
`endif
);
    typedef enum logic {RUN, MD_WAIT} state_t;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wra;
        logic              load;
        logic              md;
    } ent_t;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wra;
    } trk_t;

    if (NSTAGE_TRK != 3) begin : g_bad_cfg
        $error("hazard_ctrl supports NSTAGE_TRK == 3 only");
    end

    state_t state, state_nx;
    ent_t   e, e_nx, d_ent;
    trk_t   m, w, m_nx;
    logic   run, hold, hit1, hit2, lu, br;

    function automatic logic [1:0] fsel(input logic u, input logic [REG_AW-1:0] ra,
                                        input ent_t se, input trk_t sm, input trk_t sw);
        if (!u || ra == '0) return 2'b00;
        return (se.valid && se.wra == ra) ? 2'b01 :
               (sm.valid && sm.wra == ra) ? 2'b10 :
               (sw.valid && sw.wra == ra) ? 2'b11 : 2'b00;
    endfunction

    always_comb begin
        run        = state == RUN;
        hold       = !run && !i_md_done;
        hit1       = i_id_use1 && i_id_ra1 != '0 && e.valid && e.wra == i_id_ra1;
        hit2       = i_id_use2 && i_id_ra2 != '0 && e.valid && e.wra == i_id_ra2;
        lu         = run && i_id_valid && e.load && (hit1 || hit2);
        br         = run && i_ex_br_taken;
        // a taken branch squashes the dependent instruction, so no stall is needed
        o_stall_f  = hold || (lu && !br);
        o_stall_d  = hold || (lu && !br);
        o_stall_e  = hold;
        o_flush_d  = br;
        o_flush_e  = br || lu;
        o_md_start = run && e.md;
        o_md_busy  = !run;
        o_fwd1     = fsel(i_id_use1, i_id_ra1, e, m, w);
        o_fwd2     = fsel(i_id_use2, i_id_ra2, e, m, w);
        d_ent      = i_id_valid ? ent_t'{i_id_wen && i_id_wra != '0, i_id_wra, i_id_load, i_id_md} : '0;
        e_nx       = hold ? e : (lu || br) ? '0 : d_ent;
        m_nx       = hold ? '0 : trk_t'{e.valid, e.wra};
        state_nx   = run ? (e.md ? MD_WAIT : RUN) : (i_md_done ? RUN : MD_WAIT);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= RUN;
            e     <= '0;
            m     <= '0;
            w     <= '0;
        end else begin
            state <= state_nx;
            e     <= e_nx;
            m     <= m_nx;
            w     <= m;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_cnt_lu <= '0;
            o_cnt_br <= '0;
            o_cnt_md <= '0;
        end else begin
            if (lu && !br && ~&o_cnt_lu) o_cnt_lu <= o_cnt_lu + 32'd1;
            if (br && ~&o_cnt_br) o_cnt_br <= o_cnt_br + 32'd1;
            if (!run && ~&o_cnt_md) o_cnt_md <= o_cnt_md + 32'd1;
        end
    end
`endif
endmodule
